// File: rtl/decred_pkg.sv
// Shared definitions for the decred result collector: FSM encoding, the nonce
// base address default and an index-width helper that never returns zero.
package decred_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_READ     = 2'd1,
    S_PUSH     = 2'd2,
    S_WAIT_CLR = 2'd3
  } state_e;

  localparam logic [5:0] NONCE_BASE_DEFAULT = 6'h20;

  // A single macro still needs a 1-bit index field.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decred_result_collector_if.sv
// Host-side result read port of the collector. RD_TSTAMP exists only when
// DECRED_RESULT_TIMESTAMP_EN is defined.
interface decred_result_collector_if #(
  parameter int NUM_MACROS  = 4,
  parameter int NONCE_BYTES = 4
);
  import decred_pkg::*;

  localparam int IW = idx_w(NUM_MACROS);

  // Handshake: RD_VALID is high while a head entry is present and RD_DATA/
  // RD_MACRO describe it; RD_POP sampled with RD_VALID=1 consumes that head at
  // the clock edge, RD_POP with RD_VALID=0 has no effect.
  logic                     RD_VALID;
  logic [8*NONCE_BYTES-1:0] RD_DATA;
  logic [IW-1:0]            RD_MACRO;
  logic                     RD_POP;
`ifdef DECRED_RESULT_TIMESTAMP_EN
  logic [15:0]              RD_TSTAMP;

  modport master (output RD_VALID, output RD_DATA, output RD_MACRO,
                  output RD_TSTAMP, input RD_POP);
  modport slave  (input RD_VALID, input RD_DATA, input RD_MACRO,
                  input RD_TSTAMP, output RD_POP);
`else
  modport master (output RD_VALID, output RD_DATA, output RD_MACRO, input RD_POP);
  modport slave  (input RD_VALID, input RD_DATA, input RD_MACRO, output RD_POP);
`endif

endinterface

// File: rtl/decred_result_fifo.sv
// Synchronous FIFO with occupancy count and simultaneous push/pop; a push
// into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module decred_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != FULL_CNT) || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared too so the head outputs read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[rd_q];
  assign count     = count_q;
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);

endmodule

// File: rtl/decred_result_collector.sv
// Round-robin collector of hash-macro nonce results into a tagged FIFO with a
// level IRQ. Optional per-entry timestamps: DECRED_RESULT_TIMESTAMP_EN.
module decred_result_collector
  import decred_pkg::*;
#(
  parameter int         NUM_MACROS  = 4,
  parameter int         NONCE_BYTES = 4,
  parameter logic [5:0] NONCE_BASE  = NONCE_BASE_DEFAULT,
  parameter int         FIFO_DEPTH  = 8
) (
  input  logic                        M1_CLK,
  input  logic                        RST,
  input  logic                        ENABLE,
  input  logic [NUM_MACROS-1:0]       DATA_AVAILABLE,
  output logic [NUM_MACROS-1:0]       MACRO_RD_SELECT,
  output logic [5:0]                  HASH_ADDR,
  input  logic [7:0]                  DATA_FROM_HASH,
  decred_result_collector_if.master   rd,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_COUNT,
  output logic                        OVERFLOW,
  input  logic                        CLEAR_OVF,
  output logic                        IRQ,
  output state_e                      dbg_state
);
  localparam int IW = idx_w(NUM_MACROS);
  localparam int KW = idx_w(NONCE_BYTES);
  localparam int NW = 8 * NONCE_BYTES;
`ifdef DECRED_RESULT_TIMESTAMP_EN
  localparam int EW = NW + IW + 16;
`else
  localparam int EW = NW + IW;
`endif

  state_e                  state_q, state_d;
  logic [IW-1:0]           grant_q, grant_d, last_q, last_d;
  logic [KW-1:0]           k_q, k_d;
  logic [NW-1:0]           nonce_q, nonce_d;
  logic [NUM_MACROS-1:0]   sel_q, sel_d;
  logic [5:0]              addr_q, addr_d;
  logic                    ovf_q, ovf_d;
  logic                    push;
  logic [EW-1:0]           push_data, fifo_head;
  logic                    fifo_full, fifo_empty;

  // First requesting index strictly after `last`, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0] last,
                                            input logic [NUM_MACROS-1:0] req);
    logic [IW-1:0] pick;
    logic          found;
    int            j;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_MACROS; i++) begin
      j = (int'(last) + i) % NUM_MACROS;
      if (!found && req[j]) begin
        pick  = IW'(j);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_MACROS-1:0] onehot(input logic [IW-1:0] idx);
    logic [NUM_MACROS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_MACROS; i++) if (int'(idx) == i) v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    k_d     = k_q;
    nonce_d = nonce_q;
    sel_d   = '0;
    addr_d  = '0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ENABLE && (|DATA_AVAILABLE)) begin
          grant_d = rr_pick(last_q, DATA_AVAILABLE);
          last_d  = grant_d;
          k_d     = '0;
          sel_d   = onehot(grant_d);
          addr_d  = NONCE_BASE;
          state_d = S_READ;
        end
      end
      S_READ: begin
        nonce_d[int'(k_q)*8 +: 8] = DATA_FROM_HASH;
        if (k_q == KW'(NONCE_BYTES-1)) begin
          state_d = S_PUSH;
        end else begin
          k_d    = k_q + KW'(1);
          sel_d  = onehot(grant_q);
          addr_d = NONCE_BASE + 6'(k_q) + 6'd1;
        end
      end
      S_PUSH: begin
        push    = 1'b1;
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        // Holding here until the macro lowers its flag avoids re-reading it.
        if (!DATA_AVAILABLE[grant_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so only an unpopped full push drops.
  always_comb begin
    ovf_d = ovf_q;
    if (CLEAR_OVF) ovf_d = 1'b0;
    if (push && fifo_full && !rd.RD_POP) ovf_d = 1'b1;
  end

  always_ff @(posedge M1_CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MACROS-1);
      k_q     <= '0;
      nonce_q <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      k_q     <= k_d;
      nonce_q <= nonce_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef DECRED_RESULT_TIMESTAMP_EN
  logic [15:0] ts_ctr_q, ts_ctr_d, ts_grant_q, ts_grant_d;

  always_comb begin
    ts_ctr_d   = ts_ctr_q + 16'd1;
    ts_grant_d = ts_grant_q;
    if (state_q == S_IDLE && state_d == S_READ) ts_grant_d = ts_ctr_q;
  end

  always_ff @(posedge M1_CLK or posedge RST) begin
    if (RST) begin
      ts_ctr_q   <= '0;
      ts_grant_q <= '0;
    end else begin
      ts_ctr_q   <= ts_ctr_d;
      ts_grant_q <= ts_grant_d;
    end
  end

  assign push_data    = {ts_grant_q, grant_q, nonce_q};
  assign rd.RD_TSTAMP = fifo_head[EW-1 -: 16];
`else
  assign push_data = {grant_q, nonce_q};
`endif

  decred_result_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (M1_CLK),
    .rst       (RST),
    .push      (push),
    .push_data (push_data),
    .pop       (rd.RD_POP),
    .head_data (fifo_head),
    .count     (FIFO_COUNT),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd.RD_VALID      = !fifo_empty;
  assign rd.RD_DATA       = fifo_head[NW-1:0];
  assign rd.RD_MACRO      = fifo_head[NW+IW-1:NW];
  assign IRQ              = !fifo_empty;
  assign MACRO_RD_SELECT  = sel_q;
  assign HASH_ADDR        = addr_q;
  assign OVERFLOW         = ovf_q;
  assign dbg_state        = state_q;

endmodule
